// File: rtl/sevenseg_disp_arbiter_if.sv
// Requester-side handshake bundle for the seven-segment display arbiter:
// two valid/ready channels, each carrying a 16-bit hex word and 4 active-low dp bits.
interface sevenseg_disp_arbiter_if;
    logic        a_valid;
    logic [15:0] a_data;
    logic [3:0]  a_dp;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic [3:0]  b_dp;
    logic        b_ready;

    modport master (
        output a_valid, a_data, a_dp, b_valid, b_data, b_dp,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_data, a_dp, b_valid, b_data, b_dp,
        output a_ready, b_ready
    );
endinterface

// File: rtl/sevenseg_disp_arbiter.sv
// Round-robin arbiter sharing the 4-digit seven-segment display between two requesters;
// each grant owns the display for PRESC_MAX*HOLD_TICKS cycles.
module sevenseg_disp_arbiter #(
    parameter int PRESC_MAX  = 250000,
    parameter int HOLD_TICKS = 400,
    parameter int PRESC_W    = 18,
    parameter int HOLD_W     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    sevenseg_disp_arbiter_if.slave  req,
    output logic [3:0]              hex3,
    output logic [3:0]              hex2,
    output logic [3:0]              hex1,
    output logic [3:0]              hex0,
    output logic [3:0]              dp_out,
    output logic [1:0]              owner,
    output logic                    busy
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] HOLD_A = 2'b01;
    localparam logic [1:0] HOLD_B = 2'b10;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

    logic [1:0]         state;
    logic               last_grant_b;
    logic [PRESC_W-1:0] presc;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               tick;
    logic               expire;
    logic               a_acc;
    logic               b_acc;

    // Ready depends only on state, last grant and the valids, never on ready itself.
    always_comb begin
        req.a_ready = 1'b0;
        req.b_ready = 1'b0;
        case (state)
            IDLE: begin
                req.a_ready = req.a_valid & (~req.b_valid | last_grant_b);
                req.b_ready = req.b_valid & (~req.a_valid | ~last_grant_b);
            end
            HOLD_A:  req.a_ready = 1'b1;
            HOLD_B:  req.b_ready = 1'b1;
            default: ;
        endcase
    end

    assign a_acc  = req.a_valid & req.a_ready;
    assign b_acc  = req.b_valid & req.b_ready;
    assign tick   = (state != IDLE) && (presc == PRESC_LAST);
    assign expire = tick && (hold_cnt == HOLD_LAST);
    assign owner  = state;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            presc        <= '0;
            hold_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    presc    <= '0;
                    hold_cnt <= '0;
                    if (a_acc) begin
                        state        <= HOLD_A;
                        last_grant_b <= 1'b0;
                    end else if (b_acc) begin
                        state        <= HOLD_B;
                        last_grant_b <= 1'b1;
                    end
                end
                HOLD_A, HOLD_B: begin
                    // Owner re-sends only refresh the display; the timer keeps running.
                    presc <= tick ? '0 : presc + PRESC_W'(1);
                    if (tick) begin
                        hold_cnt <= expire ? '0 : hold_cnt + HOLD_W'(1);
                    end
                    if (expire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output latch: at most one requester can be accepted in any cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {hex3, hex2, hex1, hex0} <= 16'h0000;
            dp_out                   <= 4'b1111;
        end else if (a_acc) begin
            {hex3, hex2, hex1, hex0} <= req.a_data;
            dp_out                   <= req.a_dp;
        end else if (b_acc) begin
            {hex3, hex2, hex1, hex0} <= req.b_data;
            dp_out                   <= req.b_dp;
        end
    end

endmodule

// File: tb/tb_sevenseg_disp_arbiter.sv
// Scoreboard bench: a cycle-level ownership model predicts display, owner and ready;
// a negedge monitor compares the DUT against the queued predictions.
module tb_sevenseg_disp_arbiter;

    localparam int PM       = 4;
    localparam int HT       = 2;
    localparam int HOLD_CYC = PM * HT;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [1:0]  own;
        logic        bsy;
        logic        ar;
        logic        br;
    } rec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic [1:0]  owner;
    logic        busy;

    sevenseg_disp_arbiter_if bus ();

    sevenseg_disp_arbiter #(
        .PRESC_MAX (PM),
        .HOLD_TICKS(HT),
        .PRESC_W   (2),
        .HOLD_W    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (bus),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .dp_out(dp_out),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    rec_t q[$];
    rec_t mon_r;

    // Behavioural model: who owns the display, how many cycles remain, who went last.
    int          m_own;
    int          m_rem;
    int          m_last;
    logic [15:0] m_hex;
    logic [3:0]  m_dp;
    bit          a_pend, b_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_own  = 0;
        m_rem  = 0;
        m_last = 2;
        m_hex  = 16'h0000;
        m_dp   = 4'b1111;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_r = q.pop_front();
            chk("hex",     {hex3, hex2, hex1, hex0}, mon_r.hex);
            chk("dp_out",  dp_out,      mon_r.dp);
            chk("owner",   owner,       mon_r.own);
            chk("busy",    busy,        mon_r.bsy);
            chk("a_ready", bus.a_ready, mon_r.ar);
            chk("b_ready", bus.b_ready, mon_r.br);
        end
    end

    // One clock cycle: apply inputs, queue the prediction, advance the model across the edge.
    task automatic step(input bit rv, input bit av, input logic [15:0] ad, input logic [3:0] adp,
                        input bit bv, input logic [15:0] bd, input logic [3:0] bdp);
        bit   ar, br, a_acc, b_acc;
        rec_t r;
        reset       = rv;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.a_dp    = adp;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.b_dp    = bdp;
        if (!rv) begin
            m_reset();
            #1;
            chk("async_rst_owner", owner, 2'b00);
            chk("async_rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
            chk("async_rst_dp", dp_out, 4'b1111);
        end
        if (m_own == 0) begin
            ar = av && (!bv || m_last == 2);
            br = bv && (!av || m_last == 1);
        end else begin
            ar = (m_own == 1);
            br = (m_own == 2);
        end
        r.hex = m_hex;
        r.dp  = m_dp;
        r.own = 2'(m_own);
        r.bsy = (m_own != 0);
        r.ar  = ar;
        r.br  = br;
        q.push_back(r);
        a_acc = rv && av && ar;
        b_acc = rv && bv && br;
        if (a_acc) begin m_hex = ad; m_dp = adp; end
        if (b_acc) begin m_hex = bd; m_dp = bdp; end
        if (rv) begin
            if (m_own == 0) begin
                if (a_acc) begin m_own = 1; m_last = 1; m_rem = HOLD_CYC; end
                else if (b_acc) begin m_own = 2; m_last = 2; m_rem = HOLD_CYC; end
            end else begin
                m_rem--;
                if (m_rem == 0) m_own = 0;
            end
        end
        a_pend = av && !a_acc;
        b_pend = bv && !b_acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'hF, 1'b0, 16'h0, 4'hF);
    endtask

    logic [15:0] ra_d, rb_d;
    logic [3:0]  ra_dp, rb_dp;
    bit          rav, rbv, rrv;

    initial begin
        m_reset();
        a_pend      = 1'b0;
        b_pend      = 1'b0;
        reset       = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_data  = 16'h0;
        bus.a_dp    = 4'hF;
        bus.b_valid = 1'b0;
        bus.b_data  = 16'h0;
        bus.b_dp    = 4'hF;
        repeat (3) @(posedge clk);
        #1;

        // Reset release with no requests, then a single A grant that expires.
        idle(2);
        step(1'b1, 1'b1, 16'h1234, 4'b1110, 1'b0, 16'h0, 4'hF);
        idle(HOLD_CYC + 3);

        // Owner refresh mid-hold and again on the expiry edge while B waits.
        step(1'b1, 1'b1, 16'h1111, 4'b0111, 1'b0, 16'h0, 4'hF);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, (i == 3 || i == HOLD_CYC), (i == 3) ? 16'h5678 : 16'h9ABC, 4'b1011,
                 (i <= HOLD_CYC + 1), 16'hCCCC, 4'b1101);
        end
        idle(HOLD_CYC);

        // Reset pulsed in the middle of a B hold, then both requesters held continuously.
        step(1'b1, 1'b0, 16'h0, 4'hF, 1'b1, 16'hBEEF, 4'b0000);
        idle(3);
        step(1'b0, 1'b0, 16'h0, 4'hF, 1'b0, 16'h0, 4'hF);
        step(1'b0, 1'b0, 16'h0, 4'hF, 1'b0, 16'h0, 4'hF);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'hAAAA, 4'b1010, 1'b1, 16'hBBBB, 4'b0101);
        idle(HOLD_CYC + 2);

        // Randomized traffic honouring the handshake, with occasional async resets.
        ra_d = 16'h0; rb_d = 16'h0; ra_dp = 4'hF; rb_dp = 4'hF;
        for (int i = 0; i < 1500; i++) begin
            rrv = ($urandom_range(0, 199) != 0);
            rav = a_pend ? 1'b1 : ($urandom_range(0, 2) != 0);
            rbv = b_pend ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (!a_pend) begin ra_d = 16'($urandom); ra_dp = 4'($urandom); end
            if (!b_pend) begin rb_d = 16'($urandom); rb_dp = 4'($urandom); end
            step(rrv, rav, ra_d, ra_dp, rbv, rb_d, rb_dp);
        end
        idle(2);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
